// File: rtl/parity_check_scheduler.sv
// Round-robin scheduler sharing one 9-bit even-parity checker between NUM_REQ requesters.
// Optional per-requester saturating error counters are enabled by defining PSCHED_ERR_CNT_EN.
module parity_check_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*9-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [8:0]              rsp_data_o,
  output logic                    rsp_err_o,
`ifdef PSCHED_ERR_CNT_EN
  input  logic                    cnt_clr_i,
  output logic [NUM_REQ*CNT_W-1:0] err_cnt_o,
`endif
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic parity9(input logic [8:0] data);
    return ^data;
  endfunction

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [8:0]           chk_q, chk_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [8:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;

  logic                 grant_found_s;
  logic [ID_W-1:0]      grant_idx_s;
  logic [NUM_REQ-1:0]   grant_onehot_s;
  logic [8:0]           grant_data_s;
  logic [NUM_REQ-1:0]   req_ready_s;
  logic                 err_bit_s;

  assign err_bit_s = parity9(chk_q);

  // Round-robin search: offset k from the pointer, constant-index compare avoids wide selects.
  always_comb begin
    int idx_v;
    idx_v          = 0;
    grant_found_s  = 1'b0;
    grant_idx_s    = '0;
    grant_onehot_s = '0;
    grant_data_s   = 9'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = int'(ptr_q) + k;
      if (idx_v >= NUM_REQ) begin
        idx_v = idx_v - NUM_REQ;
      end else begin
        idx_v = idx_v;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found_s && (idx_v == i) && req_valid_i[i]) begin
          grant_found_s     = 1'b1;
          grant_idx_s       = ID_W'(i);
          grant_onehot_s[i] = 1'b1;
          grant_data_s      = req_data_i[9*i +: 9];
        end else begin
          grant_found_s = grant_found_s;
        end
      end
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    chk_d       = chk_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready_s = grant_onehot_s;
          chk_d       = grant_data_s;
          id_d        = grant_idx_s;
          if (int'(grant_idx_s) + 1 >= NUM_REQ) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_idx_s + ID_W'(1);
          end
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        rsp_err_d   = err_bit_s;
        rsp_data_d  = chk_q;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      chk_q       <= 9'd0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 9'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      chk_q       <= chk_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Grant must never be visible while reset is held, even before the first reset edge.
  assign req_ready_o = reset_i ? '0 : req_ready_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

`ifdef PSCHED_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] err_cnt_q [NUM_REQ];
  logic [CNT_W-1:0] err_cnt_d [NUM_REQ];

  // Saturating error counters; clear takes priority over a coincident increment.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      err_cnt_d[i] = err_cnt_q[i];
      if (cnt_clr_i) begin
        err_cnt_d[i] = '0;
      end else if ((state_q == ST_CHECK) && err_bit_s && (id_q == ID_W'(i))
                   && (err_cnt_q[i] != CNT_MAX)) begin
        err_cnt_d[i] = err_cnt_q[i] + CNT_W'(1);
      end else begin
        err_cnt_d[i] = err_cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset_i) begin
        err_cnt_q[i] <= '0;
      end else begin
        err_cnt_q[i] <= err_cnt_d[i];
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    err_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      err_cnt_o[CNT_W*i +: CNT_W] = err_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_parity_check_scheduler.sv
// Directed, table-driven bench for parity_check_scheduler (4 requesters, 8-bit counters).
module tb_parity_check_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*9-1:0]     req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [8:0]               rsp_data;
  logic                     rsp_err;
  logic                     busy;
`ifdef PSCHED_ERR_CNT_EN
  logic                     cnt_clr;
  logic [NUM_REQ*CNT_W-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  parity_check_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
`ifdef PSCHED_ERR_CNT_EN
    .cnt_clr_i   (cnt_clr),
    .err_cnt_o   (err_cnt),
`endif
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         req;
    logic [8:0] data;
    logic       err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req_valid = '0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // Single frame from requester r with rsp_ready high; checks the T, T+1, T+2, T+3 cycles.
  task automatic send(input int r, input logic [8:0] d, input logic exp_err);
    int n;
    logic [NUM_REQ-1:0] oh;
    n = 0;
    oh = '0;
    oh[r] = 1'b1;
    req_valid = oh;
    req_data[9*r +: 9] = d;
    rsp_ready = 1'b1;
    #1;
    while (req_ready !== oh && n < 10) begin
      step();
      #1;
      n++;
    end
    chk("grant", 64'(req_ready), 64'(oh));
    step();
    req_valid = '0;
    #1;
    chk("check_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("check_busy", 64'(busy), 64'd1);
    step();
    #1;
    chk("resp_valid", 64'(rsp_valid), 64'd1);
    chk("resp_id", 64'(rsp_id), 64'(r));
    chk("resp_err", 64'(rsp_err), 64'(exp_err));
    chk("resp_data", 64'(rsp_data), 64'(d));
    step();
    #1;
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp_rdy;
    vecs[0] = '{0, 9'b100000011, 1'b1};
    vecs[1] = '{0, 9'b100100011, 1'b0};
    vecs[2] = '{0, 9'b010011101, 1'b1};
    vecs[3] = '{0, 9'b001111101, 1'b0};
    vecs[4] = '{1, 9'h000,       1'b0};
    vecs[5] = '{3, 9'h1FF,       1'b1};
    vecs[6] = '{2, 9'h001,       1'b1};
    vecs[7] = '{1, 9'h180,       1'b0};
    vecs[8] = '{3, 9'h0F0,       1'b0};
    vecs[9] = '{2, 9'h155,       1'b1};

    reset = 1'b1;
    req_valid = 4'b1111;
    req_data = {9'h1FF, 9'h0AA, 9'h055, 9'h003};
    rsp_ready = 1'b1;
`ifdef PSCHED_ERR_CNT_EN
    cnt_clr = 1'b0;
`endif

    // Reset held with every requester asking.
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
`ifdef PSCHED_ERR_CNT_EN
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    end
    req_valid = '0;
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      send(vecs[v].req, vecs[v].data, vecs[v].err);
    end

    // All requesters held valid: grant rotates every 3 cycles from 0.
    do_reset(1);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 13; i++) begin
      exp_rdy = '0;
      if (i % 3 == 0) exp_rdy[(i / 3) % NUM_REQ] = 1'b1;
      chk("rr_ready", 64'(req_ready), 64'(exp_rdy));
      step();
      #1;
    end

    // Back-pressure in RESP for 5 cycles, then release.
    do_reset(1);
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    req_data[9*1 +: 9] = 9'b000000111;
    req_data[9*3 +: 9] = 9'b000000011;
    #1;
    chk("bp_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = 4'b1000;
    step();
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_id", 64'(rsp_id), 64'd1);
      chk("bp_rsp_err", 64'(rsp_err), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      if (i < 4) begin
        step();
        #1;
      end
    end
    rsp_ready = 1'b1;
    step();
    #1;
    chk("bp_release_valid", 64'(rsp_valid), 64'd0);
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    step();
    #1;
    chk("bp_next_rsp_id", 64'(rsp_id), 64'd3);
    chk("bp_next_rsp_err", 64'(rsp_err), 64'd0);
    step();

    // Reset during CHECK drops the frame and the pointer.
    do_reset(1);
    req_valid = 4'b0100;
    req_data[9*2 +: 9] = 9'h001;
    #1;
    chk("rc_grant", 64'(req_ready), 64'b0100);
    step();
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("rc_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rc_busy", 64'(busy), 64'd0);
    chk("rc_lowest_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    #1;
    chk("rc_no_stale_rsp", 64'(rsp_valid), 64'd0);
    step();
    step();

`ifdef PSCHED_ERR_CNT_EN
    // Saturation at 255 after 300 error frames, then clear beats increment.
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      send(2, 9'h001, 1'b1);
    end
    chk("cnt_sat_2", 64'(err_cnt[CNT_W*2 +: CNT_W]), 64'd255);
    chk("cnt_other_0", 64'(err_cnt[CNT_W*0 +: CNT_W]), 64'd0);
    chk("cnt_other_1", 64'(err_cnt[CNT_W*1 +: CNT_W]), 64'd0);
    chk("cnt_other_3", 64'(err_cnt[CNT_W*3 +: CNT_W]), 64'd0);
    req_valid = 4'b0100;
    #1;
    chk("clr_grant", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    #1;
    chk("clr_wins", 64'(err_cnt[CNT_W*2 +: CNT_W]), 64'd0);
    chk("clr_rsp_err", 64'(rsp_err), 64'd1);
    step();
    send(2, 9'h003, 1'b0);
    send(2, 9'h007, 1'b1);
    chk("cnt_after_clr", 64'(err_cnt[CNT_W*2 +: CNT_W]), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
